// File: rtl/bus_seq_ctrl.sv
// bus_seq_ctrl: sequences a three-register datapath through NOP, LOAD, MOV and SWAP commands.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   cmd_valid  in   command offered
//   cmd_ready  out  command accepted this cycle (only in idle)
//   cmd_op     in   00 NOP, 01 LOAD, 10 MOV, 11 SWAP (Reg1<->Reg2)
//   cmd_dst    in   destination register code (00 Reg1, 01 Reg2, 10 Reg3, 11 invalid)
//   cmd_src    in   source register code, MOV only
//   cmd_data   in   LOAD immediate
//   ldr_1..3   out  datapath register load strobes (at most one per cycle)
//   sel_1      out  Reg1 input select (1 = dp_data, 0 = bus)
//   sel_2      out  bus source select, register code
//   dp_data    out  captured immediate driven to the datapath
//   done, err  out  registered one-cycle completion / rejection pulses
module bus_seq_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [1:0] cmd_dst,
    input  logic [1:0] cmd_src,
    input  logic [3:0] cmd_data,
    output logic       ldr_1,
    output logic       ldr_2,
    output logic       ldr_3,
    output logic       sel_1,
    output logic [1:0] sel_2,
    output logic [3:0] dp_data,
    output logic       done,
    output logic       err
);

    localparam logic [1:0] OpNop  = 2'b00;
    localparam logic [1:0] OpLoad = 2'b01;
    localparam logic [1:0] OpMov  = 2'b10;
    localparam logic [1:0] OpSwap = 2'b11;

    localparam logic [1:0] RegR1  = 2'b00;
    localparam logic [1:0] RegR2  = 2'b01;
    localparam logic [1:0] RegR3  = 2'b10;
    localparam logic [1:0] RegBad = 2'b11;

    typedef enum logic [1:0] {StIdle, StS1, StS2, StS3} state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [1:0] r_op;
    logic [1:0] r_dst;
    logic [1:0] r_src;
    logic [3:0] r_data;
    logic       r_done;
    logic       r_err;
    logic       w_done_next;
    logic       w_err_next;
    logic       w_invalid;

    // SWAP and NOP ignore dst/src, so only LOAD/MOV can be rejected.
    assign w_invalid = (((r_op == OpLoad) || (r_op == OpMov)) && (r_dst == RegBad)) ||
                       ((r_op == OpMov) && (r_src == RegBad));

    assign cmd_ready = (r_state == StIdle);
    assign dp_data   = r_data;
    assign done      = r_done;
    assign err       = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_op    <= 2'b00;
            r_dst   <= 2'b00;
            r_src   <= 2'b00;
            r_data  <= 4'h0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;
            r_err   <= w_err_next;
            if ((r_state == StIdle) && cmd_valid) begin
                r_op   <= cmd_op;
                r_dst  <= cmd_dst;
                r_src  <= cmd_src;
                r_data <= cmd_data;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        w_err_next   = 1'b0;
        ldr_1        = 1'b0;
        ldr_2        = 1'b0;
        ldr_3        = 1'b0;
        sel_1        = 1'b0;
        sel_2        = RegR1;
        unique case (r_state)
            StIdle: begin
                if (cmd_valid) begin
                    w_state_next = StS1;
                end
            end
            StS1: begin
                w_state_next = StIdle;
                case (r_op)
                    OpLoad: begin
                        if (!w_invalid) begin
                            // Immediate always enters via Reg1, then is copied over the bus.
                            sel_1 = 1'b1;
                            ldr_1 = 1'b1;
                            if ((r_dst == RegR2) || (r_dst == RegR3)) begin
                                w_state_next = StS2;
                            end
                        end
                    end
                    OpMov: begin
                        if (!w_invalid) begin
                            sel_2 = r_src;
                            ldr_1 = (r_dst == RegR1);
                            ldr_2 = (r_dst == RegR2);
                            ldr_3 = (r_dst == RegR3);
                        end
                    end
                    OpSwap: begin
                        // Reg3 serves as the temporary and keeps old Reg1.
                        sel_2        = RegR1;
                        ldr_3        = 1'b1;
                        w_state_next = StS2;
                    end
                    default: ;
                endcase
                if (w_state_next == StIdle) begin
                    w_err_next  = w_invalid;
                    w_done_next = !w_invalid;
                end
            end
            StS2: begin
                w_state_next = StIdle;
                if (r_op == OpSwap) begin
                    sel_2        = RegR2;
                    ldr_1        = 1'b1;
                    w_state_next = StS3;
                end else begin
                    sel_2 = RegR1;
                    ldr_2 = (r_dst == RegR2);
                    ldr_3 = (r_dst == RegR3);
                end
                w_done_next = (w_state_next == StIdle);
            end
            StS3: begin
                sel_2        = RegR3;
                ldr_2        = 1'b1;
                w_state_next = StIdle;
                w_done_next  = 1'b1;
            end
            default: w_state_next = StIdle;
        endcase
    end

endmodule

// File: tb/tb_bus_seq_ctrl.sv
// tb_bus_seq_ctrl: scoreboard bench for bus_seq_ctrl with a behavioural three-register datapath.
module tb_bus_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [1:0] cmd_dst = 2'b00;
    logic [1:0] cmd_src = 2'b00;
    logic [3:0] cmd_data = 4'h0;
    logic       ldr_1, ldr_2, ldr_3, sel_1;
    logic [1:0] sel_2;
    logic [3:0] dp_data;
    logic       done, err;

    int errors = 0;
    int checks = 0;

    bus_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_dst   (cmd_dst),
        .cmd_src   (cmd_src),
        .cmd_data  (cmd_data),
        .ldr_1     (ldr_1),
        .ldr_2     (ldr_2),
        .ldr_3     (ldr_3),
        .sel_1     (sel_1),
        .sel_2     (sel_2),
        .dp_data   (dp_data),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Datapath driven by the DUT strobes; not reset, like the real registers.
    logic [3:0] m1 = 4'h0, m2 = 4'h0, m3 = 4'h0;
    logic [3:0] bus;
    always_comb begin
        case (sel_2)
            2'b00:   bus = m1;
            2'b01:   bus = m2;
            2'b10:   bus = m3;
            default: bus = 4'h0;
        endcase
    end
    always @(posedge clk) begin
        if (ldr_1) m1 <= sel_1 ? dp_data : bus;
        if (ldr_2) m2 <= bus;
        if (ldr_3) m3 <= bus;
    end

    typedef struct {
        logic        is_err;
        int          lat;
        logic [17:0] trace;
        logic [3:0]  r1, r2, r3;
    } exp_t;

    exp_t       sb_q[$];
    logic [3:0] e1 = 4'h0, e2 = 4'h0, e3 = 4'h0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Monitor: traces strobes per command and scores each done/err pulse.
    int          mon_lat = 0;
    logic        mon_active = 1'b0;
    logic [17:0] mon_trace = '0;
    always @(negedge clk) begin
        exp_t it;
        if (rst) begin
            sb_q.delete();
            mon_active = 1'b0;
        end else begin
            if (mon_active) mon_lat++;
            chk("onehot_ldr", 32'(($countones({ldr_1, ldr_2, ldr_3}) <= 1)), 32'd1);
            if (done || err) begin
                chk("done_err_excl", 32'(done && err), 32'd0);
                if (sb_q.size() == 0) begin
                    chk("unexpected_pulse", 32'd1, 32'd0);
                end else begin
                    it = sb_q.pop_front();
                    chk("pulse_kind", 32'(err), 32'(it.is_err));
                    chk("latency", 32'(mon_lat), 32'(it.lat));
                    chk("strobe_trace", 32'(mon_trace), 32'(it.trace));
                    chk("reg1", 32'(m1), 32'(it.r1));
                    chk("reg2", 32'(m2), 32'(it.r2));
                    chk("reg3", 32'(m3), 32'(it.r3));
                end
                mon_active = 1'b0;
            end else if (mon_active) begin
                mon_trace = {mon_trace[11:0], ldr_1, ldr_2, ldr_3, sel_1, sel_2};
                chk("ready_while_busy", 32'(cmd_ready), 32'd0);
            end
            if (cmd_valid && cmd_ready) begin
                mon_active = 1'b1;
                mon_lat    = 0;
                mon_trace  = '0;
            end
        end
    end

    function automatic logic [5:0] vec(input logic [2:0] ldr, input logic s1,
                                       input logic [1:0] s2);
        return {ldr, s1, s2};
    endfunction

    task automatic issue(input logic [1:0] op, input logic [1:0] dst, input logic [1:0] src,
                         input logic [3:0] data, input logic keep_valid);
        exp_t       it;
        logic [3:0] n1, n2, n3, val;
        logic [2:0] dmask;
        bit         ok;
        n1 = e1; n2 = e2; n3 = e3;
        it.is_err = 1'b0;
        it.lat    = 2;
        it.trace  = '0;
        dmask = (dst == 2'b00) ? 3'b100 : (dst == 2'b01) ? 3'b010 : 3'b001;
        case (op)
            2'b01: begin
                if (dst == 2'b11) begin
                    it.is_err = 1'b1;
                end else if (dst == 2'b00) begin
                    it.trace = 18'(vec(3'b100, 1'b1, 2'b00));
                    n1 = data;
                end else begin
                    it.lat   = 3;
                    it.trace = 18'({vec(3'b100, 1'b1, 2'b00), vec(dmask, 1'b0, 2'b00)});
                    n1 = data;
                    if (dst == 2'b01) n2 = data; else n3 = data;
                end
            end
            2'b10: begin
                if (dst == 2'b11 || src == 2'b11) begin
                    it.is_err = 1'b1;
                end else begin
                    val = (src == 2'b00) ? e1 : (src == 2'b01) ? e2 : e3;
                    it.trace = 18'(vec(dmask, 1'b0, src));
                    if (dst == 2'b00) n1 = val; else if (dst == 2'b01) n2 = val; else n3 = val;
                end
            end
            2'b11: begin
                it.lat   = 4;
                it.trace = {vec(3'b001, 1'b0, 2'b00), vec(3'b100, 1'b0, 2'b01),
                            vec(3'b010, 1'b0, 2'b10)};
                n1 = e2; n2 = e1; n3 = e1;
            end
            default: ;
        endcase
        it.r1 = n1; it.r2 = n2; it.r3 = n3;
        cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_data = data;
        cmd_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                sb_q.push_back(it);
                e1 = n1; e2 = n2; e3 = n3;
                ok = 1;
            end
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (!keep_valid) cmd_valid = 1'b0;
    endtask

    task automatic drain();
        bit empty;
        empty = 0;
        for (int i = 0; i < 40 && !empty; i++) begin
            @(posedge clk);
            if (sb_q.size() == 0) empty = 1;
        end
        if (!empty) chk("drain_timeout", 32'(sb_q.size()), 32'd0);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_ldr", 32'({ldr_1, ldr_2, ldr_3}), 32'd0);
        chk("rst_sel", 32'({sel_1, sel_2}), 32'd0);
        chk("rst_dp_data", 32'(dp_data), 32'd0);
        chk("rst_pulses", 32'({done, err}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        issue(2'b01, 2'b00, 2'b00, 4'hA, 1'b0); drain();  // LOAD Reg1=A
        issue(2'b01, 2'b10, 2'b00, 4'h5, 1'b0); drain();  // LOAD Reg3=5
        issue(2'b01, 2'b01, 2'b00, 4'hC, 1'b0); drain();  // LOAD Reg2=C
        issue(2'b01, 2'b00, 2'b00, 4'h3, 1'b0); drain();  // LOAD Reg1=3
        issue(2'b11, 2'b10, 2'b11, 4'h0, 1'b0); drain();  // SWAP
        issue(2'b10, 2'b11, 2'b01, 4'h0, 1'b0); drain();  // MOV bad dst
        issue(2'b10, 2'b00, 2'b01, 4'h0, 1'b0); drain();  // MOV Reg1<-Reg2
        issue(2'b01, 2'b11, 2'b00, 4'h7, 1'b0); drain();  // LOAD bad dst
        issue(2'b10, 2'b01, 2'b11, 4'h0, 1'b0); drain();  // MOV bad src
        issue(2'b00, 2'b11, 2'b11, 4'h2, 1'b0); drain();  // NOP
        issue(2'b01, 2'b01, 2'b00, 4'h9, 1'b0); drain();  // LOAD Reg2=9
        issue(2'b01, 2'b00, 2'b00, 4'h6, 1'b0); drain();  // LOAD Reg1=6

        // SWAP aborted by reset during S2: Reg3 took Reg1 in S1, Reg1 took Reg2 on the reset edge.
        cmd_op = 2'b11; cmd_data = 4'hF; cmd_valid = 1'b1;
        @(negedge clk);
        chk("abort_accept_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        e3 = e1;
        e1 = e2;
        @(posedge clk);
        @(negedge clk);
        chk("abort_rst_ldr", 32'({ldr_1, ldr_2, ldr_3}), 32'd0);
        chk("abort_rst_dp_data", 32'(dp_data), 32'd0);
        chk("abort_rst_pulses", 32'({done, err}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_ldr2", 32'(ldr_2), 32'd0);
            chk("abort_no_done", 32'(done), 32'd0);
            chk("abort_ready", 32'(cmd_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        issue(2'b00, 2'b00, 2'b00, 4'h0, 1'b0); drain();  // NOP to score the datapath

        // Three MOVs with cmd_valid held high throughout.
        issue(2'b10, 2'b00, 2'b10, 4'h1, 1'b1);  // Reg1<-Reg3
        issue(2'b10, 2'b01, 2'b00, 4'h2, 1'b1);  // Reg2<-Reg1
        issue(2'b10, 2'b10, 2'b10, 4'h3, 1'b0);  // Reg3<-Reg3
        drain();

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_seq_ctrl.md
BUS_SEQ_CTRL -- requirements
Module: bus_seq_ctrl

Interface
REQ-001 SHALL have parameter: none; encodings fixed. Register codes: 00=Reg1, 01=Reg2, 10=Reg3, 11=invalid.
REQ-002 SHALL have port: clk  in  1  rising-edge clock.
REQ-003 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: cmd_valid  in  1  command offered.
REQ-005 SHALL have port: cmd_ready  out  1  controller accepts a command this cycle.
REQ-006 SHALL have port: cmd_op  in  2  opcode: 00 NOP, 01 LOAD, 10 MOV, 11 SWAP (Reg1<->Reg2).
REQ-007 SHALL have port: cmd_dst  in  2  destination register code.
REQ-008 SHALL have port: cmd_src  in  2  source register code (MOV only).
REQ-009 SHALL have port: cmd_data  in  4  immediate for LOAD.
REQ-010 SHALL have ports: ldr_1, ldr_2, ldr_3  out  1 each  datapath load strobes.
REQ-011 SHALL have port: sel_1  out  1  Reg1 input select (1=dp_data, 0=bus).
REQ-012 SHALL have port: sel_2  out  2  bus source select, same code as register codes.
REQ-013 SHALL have port: dp_data  out  4  data driven to datapath data_in.
REQ-014 SHALL have ports: done  out  1, err  out  1  one-cycle completion / rejection pulses.

Function
REQ-015 SHALL accept a command on a rising edge where cmd_valid && cmd_ready, capturing op, dst, src and data; cmd_ready SHALL be 1 only in state IDLE.
REQ-016 SHALL implement FSM states IDLE, S1, S2, S3; acceptance moves IDLE->S1; each S-state lasts exactly one cycle.
REQ-017 SHALL drive outputs as a function of state and captured command only; in IDLE all ldr_* = 0, sel_1 = 0, sel_2 = 00, dp_data = captured data.
REQ-018 NOP: S1 with no strobes, then IDLE.
REQ-019 LOAD dst=Reg1: S1 {sel_1=1, ldr_1=1}, then IDLE.
REQ-020 LOAD dst=Reg2/Reg3: S1 {sel_1=1, ldr_1=1}; S2 {sel_2=00, ldr_2 or ldr_3=1}; then IDLE; Reg1 is overwritten with the immediate (documented side effect).
REQ-021 MOV: S1 {sel_2=src, sel_1=0, ldr of dst=1}, then IDLE; src==dst is legal and leaves the value unchanged.
REQ-022 SWAP: S1 {sel_2=00, ldr_3=1}; S2 {sel_2=01, sel_1=0, ldr_1=1}; S3 {sel_2=10, ldr_2=1}; then IDLE; Reg3 ends holding old Reg1.
REQ-023 SHALL assert at most one ldr_* in any cycle.
REQ-024 SHALL treat dst=11 (LOAD/MOV) or src=11 (MOV) as invalid: no strobes, S1 only, err=1 and done=0 in the cycle after S1.
REQ-025 SHALL pulse done for exactly one cycle, registered, in the first IDLE cycle after the last S-state of a valid command (including NOP).
REQ-026 Latency accept-edge to done: NOP/MOV/LOAD-Reg1 = 2 cycles, LOAD-Reg2/Reg3 = 3, SWAP = 4; back-to-back accepts allowed on the done cycle.
REQ-027 SHALL ignore cmd_* while not in IDLE; cmd_op/src/dst for SWAP are don't-care except op.

Reset
REQ-028 While rst=1 at a clock edge: state<=IDLE, captured command cleared to 0, done=0, err=0; all strobes 0 and dp_data=0 in the following cycle.
REQ-029 rst mid-command SHALL abort it with no further strobes and no done/err pulse; rst has priority over command acceptance.

Verification
REQ-030 Reset then LOAD Reg1=0xA -> ldr_1 & sel_1 high one cycle; Reg1=0xA; done 2 cycles after accept.
REQ-031 LOAD Reg3=0x5 -> cycle S1 ldr_1, cycle S2 sel_2=00 ldr_3; Reg3=0x5, Reg1=0x5; done at +3.
REQ-032 Reg1=0x3, Reg2=0xC, SWAP -> Reg1=0xC, Reg2=0x3, Reg3=0x3; strobe order ldr_3, ldr_1, ldr_2; done at +4.
REQ-033 MOV src=Reg2 dst=11 -> no strobes, err pulse at +2, registers unchanged; next command accepted normally.
REQ-034 SWAP accepted, rst asserted in S2 -> no ldr_2, no done; cmd_ready=1 after reset release.
REQ-035 cmd_valid held high with 3 queued MOVs -> each accepted only when cmd_ready=1, exactly one done per command, never two ldr_* in one cycle.
